// File: rtl/data_memory_sub.sv
// rtl/data_memory_sub.sv - byte-addressed little-endian data memory with init sequence,
// aligned/range-checked loads and stores, one-cycle load response and fault pulses.
module data_memory_sub #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    output logic            ready,
    input  logic            w,
    input  logic            r,
    input  logic [1:0]      size,
    input  logic            uns,
    input  logic [XLEN-1:0] adr,
    input  logic [XLEN-1:0] datain,
    output logic [XLEN-1:0] dataout,
    output logic            rvalid,
    output logic            fault
);

    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int AW    = $clog2(DEPTH);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [XLEN-1:0] dout_q, dout_d;
    logic            rvalid_q, rvalid_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] mem_q [DEPTH];

    logic            accept, misaligned, out_of_range, bad_size, bad;
    logic            do_load, do_store, init_we;
    logic [AW-1:0]   widx;
    logic [OFFW-1:0] boff;
    logic [OFFW+2:0] shamt;
    logic [6:0]      nbits;
    logic [XLEN-1:0] val_mask, msb, rd_word, rd_sh, ld_val, wr_mask, wr_word, init_val;

    // Outputs are forced quiet combinationally while rst is high, even mid-response.
    assign ready   = (state_q == S_RUN) && !rst;
    assign rvalid  = rvalid_q && !rst;
    assign fault   = fault_q && !rst;
    assign dataout = rvalid ? dout_q : '0;

    assign accept = req && ready;
    assign widx   = adr[AW+OFFW-1:OFFW];
    assign boff   = adr[OFFW-1:0];
    assign shamt  = {boff, 3'b000};
    assign nbits  = 7'd8 << size;

    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'd1:    misaligned = adr[0];
            2'd2:    misaligned = |adr[1:0];
            2'd3:    misaligned = |adr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign out_of_range = |adr[XLEN-1:AW+OFFW];
    assign bad_size     = (size == 2'd3) && (XLEN == 32);
    assign bad          = (w && r) || misaligned || out_of_range || bad_size;
    assign do_load      = accept && r && !w && !bad;
    assign do_store     = accept && w && !r && !bad;

    // A shift by the full width yields zero, so the double-word mask comes out all ones.
    assign val_mask = ~({XLEN{1'b1}} << nbits);
    assign msb      = val_mask & ~(val_mask >> 1);
    assign rd_word  = mem_q[widx];
    assign rd_sh    = rd_word >> shamt;
    assign ld_val   = (rd_sh & val_mask) | ((!uns && |(rd_sh & msb)) ? ~val_mask : '0);
    assign wr_mask  = val_mask << shamt;
    assign wr_word  = (rd_word & ~wr_mask) | ((datain << shamt) & wr_mask);

    assign init_we = (state_q == S_INIT) && !cnt_q[AW];

    always_comb begin
        init_val = '0;
        if (cnt_q == (AW+1)'(0))      init_val = XLEN'(15);
        else if (cnt_q == (AW+1)'(1)) init_val = XLEN'(10);
        else if (cnt_q == (AW+1)'(2)) init_val = XLEN'(100);
    end

    // Counter runs one past the last word so RUN starts DEPTH+1 cycles after reset release.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rvalid_d = do_load;
        fault_d  = accept && (w || r) && bad;
        dout_d   = do_load ? ld_val : '0;
        if (state_q == S_INIT) begin
            if (cnt_q == (AW+1)'(DEPTH)) state_d = S_RUN;
            else                         cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            fault_q  <= fault_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (init_we)       mem_q[cnt_q[AW-1:0]] <= init_val;
            else if (do_store) mem_q[widx]          <= wr_word;
        end
    end

endmodule

// File: tb/tb_data_memory_sub.sv
// tb/tb_data_memory_sub.sv - directed and randomized checks of data_memory_sub against a byte-array model.
module tb_data_memory_sub;

    localparam int XLEN  = 64;
    localparam int DEPTH = 8;
    localparam int MEMB  = DEPTH * 8;

    logic            clk = 1'b0;
    logic            rst, req, w, r, uns;
    logic [1:0]      size;
    logic [XLEN-1:0] adr, datain;
    logic            ready, rvalid, fault;
    logic [XLEN-1:0] dataout;

    logic [7:0] ref_mem [MEMB];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_memory_sub #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req(req), .ready(ready), .w(w), .r(r),
        .size(size), .uns(uns), .adr(adr), .datain(datain),
        .dataout(dataout), .rvalid(rvalid), .fault(fault)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'h00;
        ref_mem[0]  = 8'd15;
        ref_mem[8]  = 8'd10;
        ref_mem[16] = 8'd100;
    endtask

    function automatic logic [63:0] model_load(input int a, input logic [1:0] sz, input logic un);
        int nb;
        logic [63:0] v;
        nb = 1 << sz;
        v  = '0;
        for (int i = 0; i < nb; i++) v = v | (64'(ref_mem[a+i]) << (8*i));
        if (!un && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8*nb));
        return v;
    endfunction

    // Called at a negedge; applies one request and checks its response one cycle later.
    task automatic op(input logic rq, input logic wr, input logic rd, input logic [1:0] sz,
                      input logic un, input logic [63:0] a, input logic [63:0] d, input string tag);
        logic bad, ld, st, fl;
        logic [63:0] exp_data;
        int nb;
        nb  = 1 << sz;
        bad = (wr && rd) || (a % nb != 0) || (a >= MEMB);
        ld  = rq && rd && !wr && !bad;
        st  = rq && wr && !rd && !bad;
        fl  = rq && (wr || rd) && bad;
        exp_data = ld ? model_load(int'(a), sz, un) : 64'd0;
        req = rq; w = wr; r = rd; size = sz; uns = un; adr = a; datain = d;
        @(negedge clk);
        check({tag, " rvalid"}, XLEN'(rvalid), XLEN'(ld));
        check({tag, " fault"}, XLEN'(fault), XLEN'(fl));
        check({tag, " dataout"}, dataout, exp_data);
        if (st) for (int i = 0; i < nb; i++) ref_mem[int'(a)+i] = d[8*i +: 8];
    endtask

    // Called at a negedge with rst high; releases it and checks ready stays low for DEPTH+1 cycles.
    task automatic release_count(input logic stuck_store, input string tag);
        rst = 1'b0;
        req = stuck_store; w = stuck_store; r = 1'b0; size = 2'd3; adr = '0; datain = '1;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            @(negedge clk);
            check($sformatf("%s ready c%0d", tag, i), XLEN'(ready), XLEN'(i == DEPTH + 1));
            check($sformatf("%s quiet c%0d", tag, i), XLEN'({rvalid, fault}), '0);
        end
        req = 1'b0; w = 1'b0;
        model_init();
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; w = 1'b0; r = 1'b0; size = 2'd0; uns = 1'b0; adr = '0; datain = '0;
        model_init();
        repeat (2) @(negedge clk);
        check("reset ready", XLEN'(ready), '0);
        check("reset rvalid", XLEN'(rvalid), '0);
        check("reset fault", XLEN'(fault), '0);
        check("reset dataout", dataout, '0);

        // Init sequence, with a store held on req throughout to show it is ignored.
        release_count(1'b1, "init");
        for (int k = 0; k < DEPTH; k++) op(1, 0, 1, 3, 0, 64'(k*8), 0, $sformatf("init word%0d", k));
        op(1, 0, 1, 3, 0, 0, 0, "w0 again");
        check("init word0 const", dataout, 64'd15);

        op(1, 1, 0, 0, 0, 9, 64'hAB, "byte store");
        op(1, 0, 1, 3, 0, 8, 0, "byte merge");
        check("byte merge const", dataout, 64'h0000_0000_0000_AB0A);

        op(1, 1, 0, 1, 0, 32, 64'h80F0, "half store");
        op(1, 0, 1, 1, 0, 32, 0, "half signed");
        check("half signed const", dataout, 64'hFFFF_FFFF_FFFF_80F0);
        op(1, 0, 1, 1, 1, 32, 0, "half unsigned");
        check("half unsigned const", dataout, 64'h0000_0000_0000_80F0);

        op(1, 0, 1, 2, 0, 6, 0, "misaligned word");
        op(1, 1, 0, 3, 0, MEMB, 64'hDEAD, "oor store");
        op(1, 0, 1, 3, 0, MEMB - 8, 0, "last word unchanged");
        check("last word const", dataout, 64'd0);
        op(1, 1, 1, 0, 0, 0, 64'h11, "w and r");
        op(1, 0, 1, 1, 0, 33, 0, "misaligned half");
        op(1, 0, 0, 0, 0, 0, 0, "no-op");

        op(1, 0, 1, 0, 0, 40, 0, "old byte");
        op(1, 1, 0, 0, 0, 40, 64'h55, "store 55");
        op(1, 0, 1, 0, 0, 40, 0, "new byte");
        check("new byte const", dataout, 64'h55);
        op(0, 0, 0, 0, 0, 0, 0, "idle");

        for (int n = 0; n < 300; n++) begin
            logic [1:0]  sz;
            logic [63:0] a;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = 64'($urandom_range(MEMB, MEMB + 40));
            else if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, MEMB - 1));
            else a = 64'($urandom_range(0, MEMB - 1)) & ~((64'd1 << sz) - 1);
            op(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
               sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, "rand");
        end

        // Reset from RUN while a load response is on the outputs.
        req = 1'b1; w = 1'b0; r = 1'b1; size = 2'd3; adr = 8;
        @(negedge clk);
        req = 1'b0; r = 1'b0;
        check("pending rvalid", XLEN'(rvalid), XLEN'(1));
        rst = 1'b1;
        #1;
        check("rst gates ready", XLEN'(ready), '0);
        check("rst gates rvalid", XLEN'(rvalid), '0);
        check("rst gates dataout", dataout, '0);
        @(negedge clk);
        check("rst rvalid", XLEN'(rvalid), '0);
        release_count(1'b0, "rerun");
        for (int k = 0; k < 3; k++) op(1, 1, 0, 3, 0, 64'(k*8), 64'hFFFF_0000 + 64'(k), "dirty");

        // Reset arriving mid-INIT restarts from word 0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("mid-init ready", XLEN'(ready), '0);
        rst = 1'b1;
        @(negedge clk);
        release_count(1'b0, "midinit");
        for (int k = 0; k < DEPTH; k++) op(1, 0, 1, 3, 0, 64'(k*8), 0, $sformatf("reinit word%0d", k));
        op(0, 0, 0, 0, 0, 0, 0, "final idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory_sub.md
DATA_MEMORY_SUB -- requirements
Module: data_memory_sub

Interface
REQ-001 Parameter XLEN, default 64, data width in bits; SHALL be 32 or 64.
REQ-002 Parameter DEPTH, default 256, number of XLEN-bit words; SHALL be a power of two, >= 4.
REQ-003 Ports SHALL be exactly as follows:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request strobe; accepted when req && ready.
- ready  out  1  high when a request can be accepted.
- w  in  1  store request.
- r  in  1  load request.
- size  in  2  0=byte, 1=half, 2=word, 3=double (double legal only when XLEN=64).
- uns  in  1  load zero-extends when 1, sign-extends when 0.
- adr  in  XLEN  byte address.
- datain  in  XLEN  store data; the low 8*2^size bits are used.
- dataout  out  XLEN  load result.
- rvalid  out  1  dataout valid, one-cycle pulse.
- fault  out  1  one-cycle pulse flagging a rejected request.

Function
REQ-004 Storage SHALL be DEPTH words of XLEN bits, byte-addressed, little-endian; word index = adr >> log2(XLEN/8).
REQ-005 FSM states SHALL be INIT and RUN; rst forces INIT.
REQ-006 In INIT, a counter SHALL write one word per cycle, from 0 to DEPTH-1, and ready SHALL be 0.
- Words 0, 1 and 2 SHALL receive 15, 10 and 100; all other words SHALL receive 0.
REQ-007 The FSM SHALL move INIT->RUN the cycle after the write to word DEPTH-1; ready SHALL be 1 in every RUN cycle.
REQ-008 A request with req=1 while ready=0 SHALL be ignored: no write, no rvalid, no fault.
REQ-009 An accepted store SHALL update only the addressed 2^size bytes, using byte enables; other bytes of the word SHALL be unchanged.
REQ-010 An accepted load SHALL drive rvalid=1 and dataout exactly one cycle after acceptance.
- dataout SHALL be the addressed bytes, right-aligned, and sign- or zero-extended to XLEN per uns.
REQ-011 When rvalid=0, dataout SHALL be 0; high-impedance outputs are forbidden.
REQ-012 Misaligned access (adr mod 2^size != 0) SHALL be rejected:
- fault=1 one cycle after acceptance, no write, rvalid=0.
REQ-013 Out-of-range access (adr >= DEPTH*XLEN/8) SHALL be rejected the same way.
REQ-014 size=3 with XLEN=32 SHALL be rejected the same way.
REQ-015 w=1 and r=1 together SHALL be rejected the same way.
REQ-016 An accepted request with w=0 and r=0 SHALL be a no-op: no fault, no rvalid.
REQ-017 A load SHALL return data as it stood before any store in the same cycle.
- A load in the cycle after a store to the same bytes SHALL return the new data.
REQ-018 Back-to-back loads SHALL be accepted every cycle, each producing rvalid on the following cycle.
REQ-019 rvalid and fault SHALL never be high in the same cycle.

Reset
REQ-020 While rst=1, outputs SHALL be: ready=0, rvalid=0, fault=0, dataout=0.
REQ-021 rst=1 in any cycle SHALL abort any pending response and restart INIT at word 0, including when rst arrives mid-INIT.
REQ-022 The first RUN cycle SHALL occur DEPTH+1 cycles after the first cycle with rst=0.

Verification
REQ-023 Init sequence: release rst, DEPTH=8.
- ready rises after 9 cycles.
- Loads of size 3 at adr 0, 8, 16, 24 return 15, 10, 100, 0.
REQ-024 Byte merge (XLEN=64):
- Store 0xAB, size 0, at adr 9; then load size 3 at adr 8 -> 0x000000000000AB0A.
REQ-025 Sign extension:
- Store 0x80F0, size 1, at adr 32.
- Load size 1 at adr 32 with uns=0 -> 0xFFFFFFFFFFFF80F0.
- Same load with uns=1 -> 0x00000000000080F0.
REQ-026 Faults:
- Load size 2 at adr 6 -> fault pulse, rvalid=0.
- Store at adr DEPTH*8 -> fault, memory unchanged.
- w=r=1 -> fault.
REQ-027 Reset mid-INIT:
- Assert rst at init cycle 4, release it.
- ready SHALL stay low for DEPTH+1 further cycles.
- Words 0..2 reread as 15, 10, 100.
REQ-028 Same-cycle and next-cycle ordering:
- Store 0x55 at adr 40 with a simultaneous load of the same bytes via a second request in the next cycle.
- Cycle-N load returns old data; cycle-N+1 load returns 0x55.
